// File: rtl/alu_op_sequencer.sv
// Front end for the 4-bit ALU. It debounces the enter/clear buttons and steps through
// operand A, operand B and opcode entry, then captures the ALU result for display.
module alu_op_sequencer #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_CNT_W  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_data,
  input  logic [2:0] sw_op,
  input  logic       btn_enter,
  input  logic       btn_clr,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [3:0] alu_res,
  input  logic       alu_car,
  input  logic       alu_of,
  output logic [3:0] res_q,
  output logic       car_q,
  output logic       of_q,
  output logic       res_valid,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam int BTN_N = 2;  // index 0 = enter, index 1 = clear
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [BTN_N-1:0]    btn_raw;
  logic [BTN_N-1:0]    sync_1;
  logic [BTN_N-1:0]    sync_2;
  logic [BTN_N-1:0]    level;
  logic [BTN_N-1:0]    press;
  logic [DB_CNT_W-1:0] db_cnt [BTN_N];

  state_t     state_q, state_next;
  logic       enter_evt, clr_evt;
  logic       load_a, load_b, load_op, capture, clear;
  logic [3:0] a_reg, b_reg;
  logic [2:0] op_reg;

  assign btn_raw = {btn_clr, btn_enter};

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      for (int i = 0; i < BTN_N; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < BTN_N; i++) begin
        if (sync_2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // The press event fires in the cycle in which the stable level is about to flip 0->1.
  always_comb begin
    press = '0;
    for (int i = 0; i < BTN_N; i++)
      press[i] = sync_2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
  end

  assign enter_evt = press[0];
  assign clr_evt   = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_A;
    else        state_q <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state_q;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    capture    = 1'b0;
    clear      = 1'b0;
    if (clr_evt) begin
      clear      = 1'b1;
      state_next = S_A;
    end else begin
      case (state_q)
        S_A:    if (enter_evt) begin load_a  = 1'b1; state_next = S_B;    end
        S_B:    if (enter_evt) begin load_b  = 1'b1; state_next = S_OP;   end
        S_OP:   if (enter_evt) begin load_op = 1'b1; state_next = S_EXEC; end
        S_EXEC: begin capture = 1'b1; state_next = S_SHOW; end
        S_SHOW: if (enter_evt) state_next = S_A;
        default: state_next = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      res_q     <= '0;
      car_q     <= 1'b0;
      of_q      <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      res_q     <= '0;
      car_q     <= 1'b0;
      of_q      <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= capture;
      if (load_a) begin
        a_reg     <= sw_data;
        res_valid <= 1'b0;
      end
      if (load_b)  b_reg  <= sw_data;
      if (load_op) op_reg <= sw_op;
      // Flags are taken exactly as the ALU presents them, forced zeros included.
      if (capture) begin
        res_q     <= alu_res;
        car_q     <= alu_car;
        of_q      <= alu_of;
        res_valid <= 1'b1;
      end
    end
  end

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_ctrl = op_reg;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a short debounce window and a behavioural ALU;
// expected captures are queued when the opcode is entered and popped on the done pulse.
module tb_alu_op_sequencer;

  localparam int DB_CYCLES = 4;
  localparam int DB_CNT_W  = 3;
  localparam int SETTLE    = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_data = '0;
  logic [2:0] sw_op = '0;
  logic       btn_enter = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] alu_a, alu_b, alu_res, res_q;
  logic [2:0] alu_ctrl, state;
  logic       alu_car, alu_of, car_q, of_q, res_valid, done;

  int         vectors = 0;
  int         miscompares = 0;
  int         done_seen;
  logic [5:0] got;
  logic [2:0] got_prev_state;
  logic [2:0] prev_state;
  logic [5:0] sb_q [$];

  alu_op_sequencer #(.DB_CYCLES(DB_CYCLES), .DB_CNT_W(DB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .sw_op(sw_op),
    .btn_enter(btn_enter), .btn_clr(btn_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
    .res_q(res_q), .car_q(car_q), .of_q(of_q),
    .res_valid(res_valid), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream ALU: add, sub, and/or/xor/nor, signed and unsigned less-than.
  function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [4:0] w;
    logic [3:0] r;
    logic       c, o;
    c = 1'b0;
    o = 1'b0;
    case (op)
      3'b000: begin w = {1'b0, a} + {1'b0, b}; r = w[3:0]; c = w[4];
                    o = (a[3] == b[3]) && (r[3] != a[3]); end
      3'b001: begin w = {1'b0, a} - {1'b0, b}; r = w[3:0]; c = ~w[4];
                    o = (a[3] != b[3]) && (r[3] != a[3]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = ~(a | b);
      3'b110: r = {3'b000, $signed(a) < $signed(b)};
      default: r = {3'b000, a < b};
    endcase
    return {r, c, o};
  endfunction

  always_comb {alu_res, alu_car, alu_of} = alu_model(alu_a, alu_b, alu_ctrl);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      done_seen++;
      got            = {res_q, car_q, of_q};
      got_prev_state = prev_state;
    end
    prev_state = state;
  endtask

  task automatic press(input logic en, input logic cl, input int hold);
    btn_enter = en;
    btn_clr   = cl;
    repeat (hold) step();
    btn_enter = 1'b0;
    btn_clr   = 1'b0;
    repeat (SETTLE) step();
  endtask

  task automatic enter_data(input logic [3:0] d);
    sw_data = d;
    press(1'b1, 1'b0, 10);
  endtask

  task automatic enter_op(input logic [2:0] op, input logic [5:0] exp);
    sw_op = op;
    sb_q.push_back(exp);
    done_seen = 0;
    press(1'b1, 1'b0, 10);
  endtask

  task automatic expect_result(input string tag);
    logic [5:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 6'h3f;
    check({tag, "_done_count"}, done_seen, 1);
    check({tag, "_done_after_exec"}, got_prev_state, 3);
    check({tag, "_res_car_of"}, got, exp);
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_state_show"}, state, 4);
    check({tag, "_done_low"}, done, 0);
  endtask

  initial begin
    prev_state = '0;
    done_seen  = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("reset_state", state, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_res_q", res_q, 0);
    check("reset_res_valid", res_valid, 0);
    check("reset_done", done, 0);

    // 3 + 5 overflows signed 4-bit range
    enter_data(4'd3);
    check("a_entered_state", state, 1);
    enter_data(4'd5);
    check("b_entered_state", state, 2);
    enter_op(3'b000, {4'd8, 1'b0, 1'b1});
    expect_result("add_3_5");

    // 7 - 2: no borrow, so carry set
    press(1'b1, 1'b0, 10);
    check("show_to_a", state, 0);
    enter_data(4'd7);
    enter_data(4'd2);
    enter_op(3'b001, {4'd5, 1'b1, 1'b0});
    expect_result("sub_7_2");
    sw_data = 4'd15;
    repeat (20) step();
    check("show_hold_res_q", res_q, 5);
    check("show_hold_alu_a", alu_a, 7);
    check("show_hold_alu_b", alu_b, 2);

    press(1'b1, 1'b0, 10);
    check("back_to_a", state, 0);
    check("a_keeps_res_valid", res_valid, 1);
    check("a_keeps_res_q", res_q, 5);

    // glitch shorter than the debounce window
    btn_enter = 1'b1;
    repeat (3) step();
    btn_enter = 1'b0;
    repeat (SETTLE) step();
    check("glitch_no_advance", state, 0);

    // long hold: one advance, nothing on release
    press(1'b1, 1'b0, 100);
    check("hold_one_advance", state, 1);
    check("hold_a_captured", alu_a, 15);
    check("hold_res_valid_cleared", res_valid, 0);

    press(1'b0, 1'b1, 10);
    check("clr_from_b_state", state, 0);
    check("clr_from_b_alu_a", alu_a, 0);
    enter_data(4'd9);
    enter_data(4'd4);
    check("pre_clr_state", state, 2);
    check("pre_clr_alu_a", alu_a, 9);
    check("pre_clr_alu_b", alu_b, 4);
    press(1'b0, 1'b1, 10);
    check("clr_op_state", state, 0);
    check("clr_op_alu_a", alu_a, 0);
    check("clr_op_alu_b", alu_b, 0);
    check("clr_op_alu_ctrl", alu_ctrl, 0);
    check("clr_op_res_q", res_q, 0);
    check("clr_op_res_valid", res_valid, 0);

    // enter and clear in the same event cycle: clear wins
    enter_data(4'd6);
    check("pre_both_state", state, 1);
    sw_data = 4'd12;
    press(1'b1, 1'b1, 10);
    check("both_state", state, 0);
    check("both_b_not_loaded", alu_b, 0);
    check("both_a_cleared", alu_a, 0);

    enter_data(4'd2);
    enter_data(4'd3);
    enter_op(3'b000, {4'd5, 1'b0, 1'b0});
    expect_result("add_2_3");

    // asynchronous reset between clock edges while showing a result
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_res_q", res_q, 0);
    check("async_rst_res_valid", res_valid, 0);
    check("async_rst_alu_a", alu_a, 0);
    check("async_rst_alu_b", alu_b, 0);
    check("async_rst_alu_ctrl", alu_ctrl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    enter_data(4'd1);
    enter_data(4'd1);
    enter_op(3'b111, {4'd0, 1'b0, 1'b0});
    expect_result("sltu_1_1");
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
